// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider: FSM states,
// default operand width and the iteration-counter width helper.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned cnt_bits(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {rem,quo} left by one bit and
// subtract the divisor magnitude from the partial remainder if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH:0]   dvs,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    fits     = (shifted >= dvs);
    diff     = shifted - dvs;
    // The kept remainder is always below the divisor, so WIDTH bits suffice.
    rem_next = WIDTH'(fits ? diff : shifted);
    quo_next = {quo[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle signed divider (quotient on lo, remainder on hi, one bit per cycle).
// Optional DIV_UNSIGNED_EN adds the unsigned_op port for DIVU operation.
module div_seq
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef DIV_UNSIGNED_EN
  input  logic             unsigned_op,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);

  localparam int unsigned CW = cnt_bits(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem, quo;
  logic [WIDTH-1:0] rem_step, quo_step;
  logic [WIDTH:0]   dvs;
  logic             sign_a, sign_b;

  logic             signed_op;
  logic             sa, sb;
  logic             b_zero;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH:0]   mag_b;

  always_comb begin
`ifdef DIV_UNSIGNED_EN
    signed_op = !unsigned_op;
`else
    signed_op = 1'b1;
`endif
    sa     = signed_op & a[WIDTH-1];
    sb     = signed_op & b[WIDTH-1];
    b_zero = (b == '0);
    // |min_int| still fits as an unsigned WIDTH-bit value.
    mag_a  = sa ? (~a + 1'b1) : a;
    mag_b  = sb ? -{b[WIDTH-1], b} : {1'b0, b};
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem      (rem),
    .quo      (quo),
    .dvs      (dvs),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = b_zero ? DONE : CALC;
      CALC: if (count == CW'(1)) state_next = FIX;
      FIX:  state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      count    <= '0;
      rem      <= '0;
      quo      <= '0;
      dvs      <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (b_zero) begin
              div_zero <= 1'b1;
              done     <= 1'b1;
            end else begin
              sign_a <= sa;
              sign_b <= sb;
              quo    <= mag_a;
              dvs    <= mag_b;
              rem    <= '0;
              count  <= CW'(WIDTH);
              busy   <= 1'b1;
            end
          end
        end
        CALC: begin
          rem   <= rem_step;
          quo   <= quo_step;
          count <= count - 1'b1;
        end
        FIX: begin
          lo       <= (sign_a ^ sign_b) ? -quo : quo;
          hi       <= sign_a ? -rem : rem;
          done     <= 1'b1;
          busy     <= 1'b0;
          div_zero <= 1'b0;
        end
        DONE: done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule
